// File: rtl/adc_serial_reader.sv
// rtl/adc_serial_reader.sv - ADC0831-style serial ADC reader with load/error strobes
// Optional build macro ADC_PEAK_HOLD_EN: replace per-sample loads with a windowed maximum.
module adc_serial_reader #(
   parameter int CLK_DIV    = 2,
   parameter int SAMPLE_GAP = 4,
   parameter int PEAK_CNT   = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic       adc_dout,
   output logic       adc_cs_n,
   output logic       adc_sclk,
   output logic [7:0] data_out,
   output logic       load,
   output logic       error
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int GAP_W = $clog2(SAMPLE_GAP);
   localparam int BIT_W = $clog2(9);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SAMPLE_GAP - 1);
   localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(8);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SETUP = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   if (CLK_DIV < 1 || SAMPLE_GAP < 2 || PEAK_CNT < 1) begin : g_bad_param
      $error("adc_serial_reader: parameter out of range");
   end

   logic [1:0]       state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [BIT_W-1:0] bit_q, bit_d;
   logic             phase_q, phase_d;   // 1 = sclk high half-period
   logic             null_q, null_d;
   logic [7:0]       shift_q, shift_d;

   logic             cs_n_q, cs_n_d;
   logic             sclk_q, sclk_d;
   logic [7:0]       data_q, data_d;
   logic             load_q, load_d;
   logic             error_q, error_d;
   logic             finish;

`ifdef ADC_PEAK_HOLD_EN
   localparam int WIN_W = (PEAK_CNT > 1) ? $clog2(PEAK_CNT) : 1;
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(PEAK_CNT - 1);
   logic [7:0]       max_q, max_d, peak;
   logic [WIN_W-1:0] win_q, win_d;
`endif

   // Conversion sequencer: gap wait, chip-select setup, 9 sclk periods, strobe cycle
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      gap_d   = gap_q;
      bit_d   = bit_q;
      phase_d = phase_q;
      null_d  = null_q;
      shift_d = shift_q;
      unique case (state_q)
         ST_IDLE: begin
            if (gap_q != GAP_LAST) begin
               gap_d = gap_q + GAP_ONE;
            end else if (enable) begin
               state_d = ST_SETUP;
               div_d   = '0;
            end
         end
         ST_SETUP: begin
            if (div_q == DIV_LAST) begin
               // First rising sclk edge: sample the null bit
               state_d = ST_SHIFT;
               div_d   = '0;
               phase_d = 1'b1;
               bit_d   = '0;
               null_d  = adc_dout;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         ST_SHIFT: begin
            if (div_q != DIV_LAST) begin
               div_d = div_q + DIV_W'(1);
            end else begin
               div_d = '0;
               if (phase_q) begin
                  phase_d = 1'b0;
               end else if (bit_q == BIT_LAST) begin
                  state_d = ST_DONE;
               end else begin
                  phase_d = 1'b1;
                  bit_d   = bit_q + BIT_W'(1);
                  shift_d = {shift_q[6:0], adc_dout};
               end
            end
         end
         default: begin
            // Strobe cycle is the first cycle of the inter-conversion gap
            state_d = ST_IDLE;
            gap_d   = GAP_ONE;
            bit_d   = '0;
         end
      endcase
   end

   assign finish = (state_q == ST_SHIFT) && (state_d == ST_DONE);

   // Output next-state: pins follow the next FSM state so they stay registered
   always_comb begin
      cs_n_d  = !((state_d == ST_SETUP) || (state_d == ST_SHIFT));
      sclk_d  = (state_d == ST_SHIFT) && phase_d;
      data_d  = data_q;
      load_d  = 1'b0;
      error_d = 1'b0;
`ifdef ADC_PEAK_HOLD_EN
      max_d   = max_q;
      win_d   = win_q;
      peak    = (shift_q > max_q) ? shift_q : max_q;
`endif
      if (finish) begin
         if (null_q) begin
            error_d = 1'b1;
         end else begin
`ifdef ADC_PEAK_HOLD_EN
            if (win_q == WIN_LAST) begin
               load_d = 1'b1;
               data_d = peak;
               max_d  = 8'h00;
               win_d  = '0;
            end else begin
               max_d = peak;
               win_d = win_q + WIN_W'(1);
            end
`else
            load_d = 1'b1;
            data_d = shift_q;
`endif
         end
      end
   end

   // Sequencer state registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         div_q   <= '0;
         gap_q   <= '0;
         bit_q   <= '0;
         phase_q <= 1'b0;
         null_q  <= 1'b0;
         shift_q <= 8'h00;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         gap_q   <= gap_d;
         bit_q   <= bit_d;
         phase_q <= phase_d;
         null_q  <= null_d;
         shift_q <= shift_d;
      end
   end

   // Registered ADC pins and downstream strobes
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cs_n_q  <= 1'b1;
         sclk_q  <= 1'b0;
         data_q  <= 8'h00;
         load_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         cs_n_q  <= cs_n_d;
         sclk_q  <= sclk_d;
         data_q  <= data_d;
         load_q  <= load_d;
         error_q <= error_d;
      end
   end

`ifdef ADC_PEAK_HOLD_EN
   // Running maximum and window position across valid conversions
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         max_q <= 8'h00;
         win_q <= '0;
      end else begin
         max_q <= max_d;
         win_q <= win_d;
      end
   end
`endif

   assign adc_cs_n = cs_n_q;
   assign adc_sclk = sclk_q;
   assign data_out = data_q;
   assign load     = load_q;
   assign error    = error_q;

endmodule
